friscv_mem_arbiter: RTL and testbench
=====================================

// Module: friscv_mem_arbiter
//
// PURPOSE
//   Shares one memory port between the friscv_rv32i instruction fetch
//   interface (inst_*) and data load/store interface (mem_*, renamed data_*).
//   Serves one transaction at a time; buffers the winning request and
//   returns read data to its owner. Sits between the core and a single
//   unified RAM/bus bridge.
//
// PARAMETERS
//   ADDRW  16  address width for both requesters and the memory port
//   XLEN   32  data width; strobe width is XLEN/8
//
// PORTS
//   aclk        in   1        clock
//   srst        in   1        synchronous reset, active high
//   inst_en     in   1        fetch request, held until inst_ready
//   inst_addr   in   ADDRW    fetch address
//   inst_rdata  out  XLEN     fetch data, valid with inst_ready
//   inst_ready  out  1        one-cycle completion pulse to fetch
//   data_en     in   1        load/store request, held until data_ready
//   data_wr     in   1        1 = store, 0 = load
//   data_addr   in   ADDRW    load/store address
//   data_wdata  in   XLEN     store data
//   data_strb   in   XLEN/8   store byte enables
//   data_rdata  out  XLEN     load data, valid with data_ready
//   data_ready  out  1        one-cycle completion pulse to load/store
//   mem_en      out  1        memory request, held until mem_ready
//   mem_wr      out  1        memory write
//   mem_addr    out  ADDRW    memory address
//   mem_wdata   out  XLEN     memory write data
//   mem_strb    out  XLEN/8   memory byte enables
//   mem_rdata   in   XLEN     memory read data, valid with mem_ready
//   mem_ready   in   1        memory completion; may assert in first mem_en cycle
//   grant       out  2        current owner: 00 none, 01 inst, 10 data
//
// BEHAVIOUR
//   - All outputs registered. Reset value of every output is 0.
//   - FSM: IDLE -> GNT_INST | GNT_DATA -> RESP -> IDLE.
//   - IDLE: samples inst_en/data_en. Grant is latched with a payload copy of
//     addr/wr/wdata/strb; inst grant drives mem_wr=0, mem_strb=0.
//     No request: stay IDLE.
//   - GNT_x: mem_en=1 with stable payload until a cycle where mem_ready=1.
//     The next edge drops mem_en, captures mem_rdata and enters RESP.
//   - RESP: owner's ready=1 for exactly one cycle. Owner's rdata is updated
//     (stores return 0). Non-owner rdata holds. Next state is IDLE.
//   - Latency: request seen in IDLE at cycle N -> mem_en at N+1.
//     mem_ready at N+1+L (L>=0) -> ready pulse at N+2+L.
//     Minimum 3 cycles per transaction.
//   - Requester en is sampled only in IDLE. The cycle after ready is a new
//     request if en is still high. Requester payload changes while waiting
//     are ignored (payload latched).
//   - Tie (both en high in IDLE): see CONFIGURATION. A losing request stays
//     pending and is served on the next IDLE.
//   - mem_ready outside GNT_x is ignored.
//   - srst mid-transaction: FSM to IDLE, mem_en dropped, no ready pulse
//     issued, last-grant history reset to INST.
//
// CONFIGURATION
//   FRISCV_ARB_RR_EN defined: round-robin on tie. Grant goes to the requester
//     not served last. Last-grant is initialised to INST, so the first tie
//     goes to DATA.
//   Undefined: fixed priority, data always wins a tie. Fetch can starve under
//     continuous data requests (acceptable: the core stalls fetch during LSU
//     ops).
//
// TESTING
//   1. Fetch only: inst_en=1, inst_addr=0x0010, mem_ready same cycle as
//      mem_en, mem_rdata=0x00000013 -> mem_en 1 cycle, inst_ready pulse 1
//      cycle later, inst_rdata=0x00000013, data_ready never asserts.
//   2. Store: data_en=1, wr=1, addr=0x0100, wdata=0xDEADBEEF, strb=0xF,
//      mem_ready after 3 cycles -> mem_en high 4 cycles with stable payload,
//      data_ready 1 cycle after mem_ready.
//   3. Tie, macro undefined: both en held high for 4 transactions ->
//      all 4 grants DATA; inst_ready never pulses.
//   4. Tie, FRISCV_ARB_RR_EN: both en held high -> grants DATA, INST, DATA,
//      INST; each ready pulse goes to the matching owner with its own rdata.
//   5. Reset mid-op: srst asserted while GNT_DATA and mem_en=1 -> next cycle
//      mem_en=0, grant=00, no data_ready; a following fetch is served
//      normally.
//   6. Payload hold: change data_addr 0x0100->0x0200 while waiting ->
//      mem_addr stays 0x0100 until completion.

Source files
------------

// File: rtl/friscv_mem_arbiter.sv
// friscv_mem_arbiter
//   Shares one memory port between the friscv_rv32i instruction fetch
//   requester (inst_*) and the load/store requester (data_*). One
//   transaction is in flight at a time; the winning request payload is
//   latched at grant and read data is returned only to its owner.
//
//   Optional feature macro: FRISCV_ARB_RR_EN
//     defined   - round-robin on a tie (the requester not served last wins;
//                 history starts at INST so the first tie goes to DATA)
//     undefined - fixed priority, DATA wins every tie
//
// Ports
//   i_aclk, i_srst              clock, synchronous active-high reset
//   i_inst_en/i_inst_addr       fetch request, held until o_inst_ready
//   o_inst_rdata/o_inst_ready   fetch data + one-cycle completion pulse
//   i_data_en/_wr/_addr/_wdata/_strb  load/store request, held until o_data_ready
//   o_data_rdata/o_data_ready   load data (0 for stores) + completion pulse
//   o_mem_en/_wr/_addr/_wdata/_strb   memory request, held until i_mem_ready
//   i_mem_rdata/i_mem_ready     memory response
//   o_grant                     owner: 00 none, 01 inst, 10 data
module friscv_mem_arbiter #(
    parameter int unsigned ADDRW = 16,
    parameter int unsigned XLEN  = 32
) (
    input  logic                i_aclk,
    input  logic                i_srst,
    input  logic                i_inst_en,
    input  logic [ADDRW-1:0]    i_inst_addr,
    output logic [XLEN-1:0]     o_inst_rdata,
    output logic                o_inst_ready,
    input  logic                i_data_en,
    input  logic                i_data_wr,
    input  logic [ADDRW-1:0]    i_data_addr,
    input  logic [XLEN-1:0]     i_data_wdata,
    input  logic [XLEN/8-1:0]   i_data_strb,
    output logic [XLEN-1:0]     o_data_rdata,
    output logic                o_data_ready,
    output logic                o_mem_en,
    output logic                o_mem_wr,
    output logic [ADDRW-1:0]    o_mem_addr,
    output logic [XLEN-1:0]     o_mem_wdata,
    output logic [XLEN/8-1:0]   o_mem_strb,
    input  logic [XLEN-1:0]     i_mem_rdata,
    input  logic                i_mem_ready,
    output logic [1:0]          o_grant
);

    localparam int unsigned STRBW = XLEN / 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GNT_INST = 2'd1,
        ST_GNT_DATA = 2'd2,
        ST_RESP     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_mem_en,     w_mem_en_nxt;
    logic               r_mem_wr,     w_mem_wr_nxt;
    logic [ADDRW-1:0]   r_mem_addr,   w_mem_addr_nxt;
    logic [XLEN-1:0]    r_mem_wdata,  w_mem_wdata_nxt;
    logic [STRBW-1:0]   r_mem_strb,   w_mem_strb_nxt;
    logic [XLEN-1:0]    r_inst_rdata, w_inst_rdata_nxt;
    logic [XLEN-1:0]    r_data_rdata, w_data_rdata_nxt;
    logic               r_inst_ready, w_inst_ready_nxt;
    logic               r_data_ready, w_data_ready_nxt;
    logic [1:0]         r_grant,      w_grant_nxt;

    logic               w_req_any;
    logic               w_pick_data;

    assign w_req_any = i_inst_en | i_data_en;

`ifdef FRISCV_ARB_RR_EN
    // 1 when the most recent grant went to DATA
    logic r_last_data;

    // on a tie, DATA wins only if INST was served last
    assign w_pick_data = i_data_en & (~i_inst_en | ~r_last_data);

    always_ff @(posedge i_aclk) begin
        if (i_srst) begin
            r_last_data <= 1'b0;
        end else if (r_state == ST_IDLE && w_req_any) begin
            r_last_data <= w_pick_data;
        end
    end
`else
    // fixed priority: any data request wins
    assign w_pick_data = i_data_en;
`endif

    // state register
    always_ff @(posedge i_aclk) begin
        if (i_srst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req_any) begin
                    w_state_nxt = w_pick_data ? ST_GNT_DATA : ST_GNT_INST;
                end
            end
            ST_GNT_INST, ST_GNT_DATA: begin
                if (i_mem_ready) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // next values of the registered outputs; payload is latched at grant
    always_comb begin
        w_mem_en_nxt     = r_mem_en;
        w_mem_wr_nxt     = r_mem_wr;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_mem_strb_nxt   = r_mem_strb;
        w_inst_rdata_nxt = r_inst_rdata;
        w_data_rdata_nxt = r_data_rdata;
        w_inst_ready_nxt = 1'b0;
        w_data_ready_nxt = 1'b0;
        w_grant_nxt      = r_grant;
        case (r_state)
            ST_IDLE: begin
                if (w_req_any) begin
                    w_mem_en_nxt = 1'b1;
                    if (w_pick_data) begin
                        w_grant_nxt     = 2'b10;
                        w_mem_wr_nxt    = i_data_wr;
                        w_mem_addr_nxt  = i_data_addr;
                        w_mem_wdata_nxt = i_data_wdata;
                        w_mem_strb_nxt  = i_data_strb;
                    end else begin
                        w_grant_nxt     = 2'b01;
                        w_mem_wr_nxt    = 1'b0;
                        w_mem_addr_nxt  = i_inst_addr;
                        w_mem_wdata_nxt = '0;
                        w_mem_strb_nxt  = '0;
                    end
                end
            end
            ST_GNT_INST: begin
                if (i_mem_ready) begin
                    w_mem_en_nxt     = 1'b0;
                    w_inst_rdata_nxt = i_mem_rdata;
                    w_inst_ready_nxt = 1'b1;
                end
            end
            ST_GNT_DATA: begin
                if (i_mem_ready) begin
                    w_mem_en_nxt     = 1'b0;
                    // stores hand back zero rather than bus garbage
                    w_data_rdata_nxt = r_mem_wr ? '0 : i_mem_rdata;
                    w_data_ready_nxt = 1'b1;
                end
            end
            ST_RESP: w_grant_nxt = 2'b00;
            default: ;
        endcase
    end

    // output registers
    always_ff @(posedge i_aclk) begin
        if (i_srst) begin
            r_mem_en     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_strb   <= '0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
            r_inst_ready <= 1'b0;
            r_data_ready <= 1'b0;
            r_grant      <= 2'b00;
        end else begin
            r_mem_en     <= w_mem_en_nxt;
            r_mem_wr     <= w_mem_wr_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_strb   <= w_mem_strb_nxt;
            r_inst_rdata <= w_inst_rdata_nxt;
            r_data_rdata <= w_data_rdata_nxt;
            r_inst_ready <= w_inst_ready_nxt;
            r_data_ready <= w_data_ready_nxt;
            r_grant      <= w_grant_nxt;
        end
    end

    assign o_mem_en     = r_mem_en;
    assign o_mem_wr     = r_mem_wr;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_mem_strb   = r_mem_strb;
    assign o_inst_rdata = r_inst_rdata;
    assign o_data_rdata = r_data_rdata;
    assign o_inst_ready = r_inst_ready;
    assign o_data_ready = r_data_ready;
    assign o_grant      = r_grant;

endmodule

// File: tb/tb_friscv_mem_arbiter.sv
// Self-checking bench for friscv_mem_arbiter: directed cases followed by
// randomized request traffic checked against a transaction-level model.
module tb_friscv_mem_arbiter;

    localparam int unsigned ADDRW = 16;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned STRBW = XLEN / 8;

    logic               clk = 1'b0;
    logic               srst;
    logic               inst_en;
    logic [ADDRW-1:0]   inst_addr;
    logic [XLEN-1:0]    inst_rdata;
    logic               inst_ready;
    logic               data_en;
    logic               data_wr;
    logic [ADDRW-1:0]   data_addr;
    logic [XLEN-1:0]    data_wdata;
    logic [STRBW-1:0]   data_strb;
    logic [XLEN-1:0]    data_rdata;
    logic               data_ready;
    logic               mem_en;
    logic               mem_wr;
    logic [ADDRW-1:0]   mem_addr;
    logic [XLEN-1:0]    mem_wdata;
    logic [STRBW-1:0]   mem_strb;
    logic [XLEN-1:0]    mem_rdata;
    logic               mem_ready;
    logic [1:0]         grant;

    always #5 clk = ~clk;

    friscv_mem_arbiter #(.ADDRW(ADDRW), .XLEN(XLEN)) dut (
        .i_aclk       (clk),
        .i_srst       (srst),
        .i_inst_en    (inst_en),
        .i_inst_addr  (inst_addr),
        .o_inst_rdata (inst_rdata),
        .o_inst_ready (inst_ready),
        .i_data_en    (data_en),
        .i_data_wr    (data_wr),
        .i_data_addr  (data_addr),
        .i_data_wdata (data_wdata),
        .i_data_strb  (data_strb),
        .o_data_rdata (data_rdata),
        .o_data_ready (data_ready),
        .o_mem_en     (mem_en),
        .o_mem_wr     (mem_wr),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_strb   (mem_strb),
        .i_mem_rdata  (mem_rdata),
        .i_mem_ready  (mem_ready),
        .o_grant      (grant)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // transaction-level model state
    bit               m_last_data;
    logic [XLEN-1:0]  m_inst_rdata;
    logic [XLEN-1:0]  m_data_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // arbitration rule applied to the requests seen in an idle cycle
    function automatic bit model_pick_data(input bit ie, input bit de);
        if (!ie) return 1'b1;
        if (!de) return 1'b0;
`ifdef FRISCV_ARB_RR_EN
        return !m_last_data;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check_idle(input string tag);
        check({tag, ".mem_en"},     32'(mem_en),     32'd0);
        check({tag, ".grant"},      32'(grant),      32'd0);
        check({tag, ".inst_ready"}, 32'(inst_ready), 32'd0);
        check({tag, ".data_ready"}, 32'(data_ready), 32'd0);
    endtask

    // Starts in an idle cycle with requests already driven; ends in the
    // following idle cycle. lat = wait cycles before mem_ready.
    task automatic run_txn(input int lat, input logic [XLEN-1:0] rd,
                           input bit chg, input bit drop);
        bit               own_data;
        logic [ADDRW-1:0] ea;
        logic             ew;
        logic [XLEN-1:0]  ewd;
        logic [STRBW-1:0] es;
        logic [1:0]       eg;
        own_data = model_pick_data(inst_en, data_en);
        if (own_data) begin
            ea = data_addr; ew = data_wr; ewd = data_wdata; es = data_strb; eg = 2'b10;
        end else begin
            ea = inst_addr; ew = 1'b0; ewd = '0; es = '0; eg = 2'b01;
        end
        m_last_data = own_data;
        tick();
        for (int k = 0; k <= lat; k++) begin
            check("gnt.mem_en",     32'(mem_en),     32'd1);
            check("gnt.grant",      32'(grant),      32'(eg));
            check("gnt.mem_addr",   32'(mem_addr),   32'(ea));
            check("gnt.mem_wr",     32'(mem_wr),     32'(ew));
            check("gnt.mem_strb",   32'(mem_strb),   32'(es));
            if (own_data) check("gnt.mem_wdata", mem_wdata, ewd);
            check("gnt.inst_ready", 32'(inst_ready), 32'd0);
            check("gnt.data_ready", 32'(data_ready), 32'd0);
            if (chg && k == 0) begin
                inst_addr  = ~inst_addr;
                data_addr  = data_addr ^ 16'h0300;
                data_wdata = ~data_wdata;
            end
            mem_ready = (k == lat);
            mem_rdata = (k == lat) ? rd : $urandom;
            tick();
        end
        // mem_ready outside a grant must be ignored
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        if (own_data) m_data_rdata = ew ? '0 : rd;
        else          m_inst_rdata = rd;
        check("resp.mem_en",     32'(mem_en),     32'd0);
        check("resp.grant",      32'(grant),      32'(eg));
        check("resp.inst_ready", 32'(inst_ready), 32'(!own_data));
        check("resp.data_ready", 32'(data_ready), 32'(own_data));
        check("resp.inst_rdata", inst_rdata, m_inst_rdata);
        check("resp.data_rdata", data_rdata, m_data_rdata);
        if (drop) begin
            if (own_data) data_en = 1'b0;
            else          inst_en = 1'b0;
        end
        tick();
        check_idle("post");
    endtask

    initial begin
        srst = 1'b1; inst_en = 1'b0; inst_addr = '0;
        data_en = 1'b0; data_wr = 1'b0; data_addr = '0; data_wdata = '0; data_strb = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        m_last_data = 1'b0; m_inst_rdata = '0; m_data_rdata = '0;
        tick();
        tick();
        check_idle("reset");
        check("reset.mem_addr",   32'(mem_addr), 32'd0);
        check("reset.mem_wr",     32'(mem_wr),   32'd0);
        check("reset.mem_strb",   32'(mem_strb), 32'd0);
        check("reset.mem_wdata",  mem_wdata,     32'd0);
        check("reset.inst_rdata", inst_rdata,    32'd0);
        check("reset.data_rdata", data_rdata,    32'd0);
        srst = 1'b0;
        tick();

        // stray mem_ready with no request
        mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        tick();
        check_idle("stray");
        check("stray.inst_rdata", inst_rdata, 32'd0);
        mem_ready = 1'b0;

        // fetch with same-cycle memory completion
        inst_en = 1'b1; inst_addr = 16'h0010;
        run_txn(0, 32'h0000_0013, 1'b0, 1'b1);

        // store with three wait cycles
        data_en = 1'b1; data_wr = 1'b1; data_addr = 16'h0100;
        data_wdata = 32'hDEAD_BEEF; data_strb = 4'hF;
        run_txn(3, 32'h1234_5678, 1'b0, 1'b1);

        // load whose requester payload moves while waiting
        data_en = 1'b1; data_wr = 1'b0; data_addr = 16'h0100;
        data_wdata = 32'h0BAD_F00D; data_strb = 4'h0;
        run_txn(2, 32'hCAFE_0001, 1'b1, 1'b1);
        check("hold.req_addr_moved", 32'(data_addr), 32'h0200);

        // both requesters held high across four transactions
        inst_en = 1'b1; inst_addr = 16'h0040;
        data_en = 1'b1; data_wr = 1'b0; data_addr = 16'h0080; data_strb = 4'h3;
        for (int t = 0; t < 4; t++) begin
            run_txn($urandom_range(0, 2), $urandom, 1'b0, 1'b0);
        end
        inst_en = 1'b0; data_en = 1'b0;
        tick();
        check_idle("tie.done");

        // reset while a data grant is outstanding
        data_en = 1'b1; data_wr = 1'b0; data_addr = 16'h0300;
        tick();
        check("rst.mem_en_before", 32'(mem_en), 32'd1);
        check("rst.grant_before",  32'(grant),  32'h2);
        srst = 1'b1;
        tick();
        check_idle("rst");
        check("rst.data_rdata", data_rdata, 32'd0);
        check("rst.inst_rdata", inst_rdata, 32'd0);
        srst = 1'b0; data_en = 1'b0;
        m_last_data = 1'b0; m_inst_rdata = '0; m_data_rdata = '0;
        tick();
        check_idle("rst.idle");
        inst_en = 1'b1; inst_addr = 16'h0020;
        run_txn(1, 32'h0000_0093, 1'b0, 1'b1);

        // tie right after reset recovery
        inst_en = 1'b1; inst_addr = 16'h0024;
        data_en = 1'b1; data_wr = 1'b1; data_addr = 16'h0110;
        data_wdata = 32'h0102_0304; data_strb = 4'h5;
        run_txn(0, $urandom, 1'b0, 1'b1);
        run_txn(1, $urandom, 1'b0, 1'b1);
        inst_en = 1'b0; data_en = 1'b0;

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            if (!inst_en && $urandom_range(0, 1) == 1) begin
                inst_en = 1'b1; inst_addr = 16'($urandom);
            end
            if (!data_en && $urandom_range(0, 1) == 1) begin
                data_en = 1'b1; data_wr = 1'($urandom_range(0, 1));
                data_addr = 16'($urandom); data_wdata = $urandom;
                data_strb = 4'($urandom);
            end
            if (!inst_en && !data_en) begin
                tick();
                check_idle("rand.idle");
            end else begin
                run_txn($urandom_range(0, 3), $urandom,
                        $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
